xadac_dcache_arbiter: RTL and testbench
=======================================

// Module: xadac_dcache_arbiter
// PURPOSE
//  Shares one CVA6 D$ request port between NumReq requesters (e.g. the XADAC
//  vector adapter's read and write channels) using round-robin arbitration.
//  Allows one transaction in flight at a time. Routes the read response back
//  to its owner.
//  Sits between dcache_axi_adapter and a cache port of cva6 inside ariane.
// PARAMETERS
//  NumReq     2   number of requesters (>=2)
//  AddrWidth  64  request address width
//  DataWidth  64  data width; byte enables are DataWidth/8 bits
// PORTS
//  clk_i          in   1                clock
//  rst_i          in   1                synchronous, active-high reset
//  req_valid_i    in   NumReq           per-requester request; must hold until req_gnt_o
//  req_we_i       in   NumReq           1 = write, 0 = read
//  req_addr_i     in   NumReq*AddrWidth request address
//  req_wdata_i    in   NumReq*DataWidth write data
//  req_be_i       in   NumReq*DW/8      byte enables
//  req_size_i     in   NumReq*2         log2 of access size in bytes
//  req_gnt_o      out  NumReq           one-hot grant pulse, one cycle
//  rsp_valid_o    out  NumReq           one-hot read-data-valid pulse
//  rsp_rdata_o    out  DataWidth        read data, shared by all requesters
//  dc_req_o       out  1                D$ request
//  dc_we_o / dc_addr_o / dc_wdata_o / dc_be_o / dc_size_o  out  fields of the selected requester
//  dc_gnt_i       in   1                D$ grant
//  dc_rvalid_i    in   1                D$ read data valid
//  dc_rdata_i     in   DataWidth        D$ read data
//  busy_o         out  1                state != IDLE
//  spurious_rsp_o out  1                pulse: dc_rvalid_i arrived while no read was pending
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, owner=0; all outputs 0.
//  FSM states: IDLE, HOLD, WAIT_RSP.
//  IDLE:
//   - Selection is combinational: the first valid requester at or after rr_ptr
//     (modulo NumReq) becomes sel.
//   - If any requester is valid: dc_req_o=1, the dc_* fields carry sel's fields,
//     and owner is latched to sel.
//   - On dc_gnt_i in the same cycle: req_gnt_o[sel] pulses and rr_ptr becomes
//     sel+1 (mod NumReq). The next state is WAIT_RSP for a read and IDLE for a write.
//   - Without dc_gnt_i: the next state is HOLD.
//  HOLD:
//   - dc_req_o=1 and the dc_* fields carry the owner's fields. Arbitration is frozen.
//   - On dc_gnt_i: same actions as IDLE's grant.
//   - If req_valid_i[owner] drops before grant (protocol violation): assert,
//     then return to IDLE without a grant.
//  WAIT_RSP:
//   - dc_req_o=0.
//   - On dc_rvalid_i: rsp_valid_o[owner]=1, rsp_rdata_o=dc_rdata_i, next state IDLE.
//  Timing and throughput:
//   - Write latency is 0 cycles from request to grant when D$ grants immediately.
//   - The cycle in which the read response returns cannot issue a new request
//     (one bubble). Back-to-back writes run at 1 per cycle.
//  dc_rvalid_i rules:
//   - In the same cycle as dc_gnt_i: illegal (asserted). The D$ guarantees at least one cycle.
//   - In IDLE or HOLD: dropped, and spurious_rsp_o pulses.
//  Requesters without a grant see no req_gnt_o and keep waiting; no request is ever dropped.
//  Fairness: a continuously requesting port waits at most NumReq-1 transactions.
//  Reset mid-transaction: rst_i forces IDLE immediately and abandons the pending read.
//   A late rvalid from that read raises spurious_rsp_o and is not forwarded.
//  Write data and byte enables pass through unregistered.
//  All dc_* data fields are 0 while dc_req_o=0.
// TESTING
//  1. Single write, port0, addr 0x80001000, be 0xFF, dc_gnt_i the same cycle
//     -> req_gnt_o=01 in that cycle; busy_o stays 0 the next cycle.
//  2. Read, port1, addr 0x80002008; gnt at t0, rvalid at t0+3 with data 0xDEADBEEF
//     -> rsp_valid_o=10 at t0+3, rsp_rdata_o=0xDEADBEEF, state IDLE at t0+4.
//  3. Both ports valid continuously, D$ always grants writes
//     -> grants alternate 01,10,01,10 starting with port0.
//  4. dc_gnt_i withheld 5 cycles while port0 is selected; port1 raises valid meanwhile
//     -> dc_addr_o stays at port0's address; port0 is granted first, then port1.
//  5. rst_i pulsed in WAIT_RSP, then dc_rvalid_i 2 cycles later
//     -> rsp_valid_o=00; spurious_rsp_o=1 for one cycle.
//  6. Read granted, then port0 write requested while in WAIT_RSP
//     -> dc_req_o=0 until the cycle after rvalid, then the write is issued.

Source files
------------

// File: rtl/xadac_dcache_arbiter.sv
// Round-robin arbiter sharing one D$ request port between NumReq requesters,
// one transaction in flight, read responses routed back to their owner.
module xadac_dcache_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq-1:0]               req_we_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0] req_be_i,
  input  logic [NumReq*2-1:0]             req_size_i,
  output logic [NumReq-1:0]               req_gnt_o,
  output logic [NumReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            dc_req_o,
  output logic                            dc_we_o,
  output logic [AddrWidth-1:0]            dc_addr_o,
  output logic [DataWidth-1:0]            dc_wdata_o,
  output logic [DataWidth/8-1:0]          dc_be_o,
  output logic [1:0]                      dc_size_o,
  input  logic                            dc_gnt_i,
  input  logic                            dc_rvalid_i,
  input  logic [DataWidth-1:0]            dc_rdata_i,
  output logic                            busy_o,
  output logic                            spurious_rsp_o,
  output logic [1:0]                      dbg_state_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeW  = DataWidth / 8;

  // Handshake: a requester holds req_valid_i and its fields stable until it sees
  // a one-cycle req_gnt_o; the D$ transfer happens in the cycle dc_req_o && dc_gnt_i.
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, WAIT_RSP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d, owner_q, owner_d, sel, pick, idx;
  logic            any_valid, grant;

  // Scan downward so the lowest offset from rr_q is the last (winning) match.
  always_comb begin
    sel       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      idx = IdxW'((int'(rr_q) + i) % int'(NumReq));
      if (req_valid_i[idx]) begin
        sel       = idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    pick        = owner_q;
    grant       = 1'b0;
    dc_req_o    = 1'b0;
    req_gnt_o   = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    case (state_q)
      IDLE: begin
        pick = sel;
        if (any_valid) begin
          dc_req_o = 1'b1;
          owner_d  = sel;
          if (dc_gnt_i) grant = 1'b1;
          else          state_d = HOLD;
        end
      end
      HOLD: begin
        // A dropped request abandons the hold without ever granting it.
        if (req_valid_i[owner_q]) begin
          dc_req_o = 1'b1;
          if (dc_gnt_i) grant = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        if (dc_rvalid_i) begin
          rsp_valid_o[owner_q] = 1'b1;
          rsp_rdata_o          = dc_rdata_i;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      req_gnt_o[pick] = 1'b1;
      rr_d            = (pick == IdxW'(NumReq - 1)) ? '0 : pick + 1'b1;
      state_d         = req_we_i[pick] ? IDLE : WAIT_RSP;
    end
  end

  assign dc_we_o    = dc_req_o & req_we_i[pick];
  assign dc_addr_o  = dc_req_o ? req_addr_i[pick*AddrWidth +: AddrWidth] : '0;
  assign dc_wdata_o = dc_req_o ? req_wdata_i[pick*DataWidth +: DataWidth] : '0;
  assign dc_be_o    = dc_req_o ? req_be_i[pick*BeW +: BeW] : '0;
  assign dc_size_o  = dc_req_o ? req_size_i[pick*2 +: 2] : '0;

  assign busy_o         = (state_q != IDLE);
  assign spurious_rsp_o = dc_rvalid_i && (state_q != WAIT_RSP);
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD) |-> req_valid_i[owner_q]);
  a_gnt_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dc_gnt_i && dc_rvalid_i));

endmodule

// File: tb/tb_xadac_dcache_arbiter.sv
// Directed bench for xadac_dcache_arbiter: per-cycle vector table plus
// hand-written reset-during-read sequence.
module tb_xadac_dcache_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   req_valid_i, req_we_i;
  logic [127:0] req_addr_i, req_wdata_i;
  logic [15:0]  req_be_i;
  logic [3:0]   req_size_i;
  logic [1:0]   req_gnt_o, rsp_valid_o;
  logic [63:0]  rsp_rdata_o;
  logic         dc_req_o, dc_we_o;
  logic [63:0]  dc_addr_o, dc_wdata_o;
  logic [7:0]   dc_be_o;
  logic [1:0]   dc_size_o;
  logic         dc_gnt_i, dc_rvalid_i;
  logic [63:0]  dc_rdata_i;
  logic         busy_o, spurious_rsp_o;
  logic [1:0]   dbg_state_o;

  always #5 clk_i = ~clk_i;

  xadac_dcache_arbiter #(.NumReq(2), .AddrWidth(64), .DataWidth(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_size_i(req_size_i),
    .req_gnt_o(req_gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .dc_req_o(dc_req_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
    .dc_wdata_o(dc_wdata_o), .dc_be_o(dc_be_o), .dc_size_o(dc_size_o),
    .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i),
    .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o), .dbg_state_o(dbg_state_o)
  );

  // Fixed per-port request fields; port index 2 means "nothing on the D$ bus".
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata[2];
  logic [7:0]  p_be   [2];
  logic [1:0]  p_size [2];

  typedef struct {
    logic [1:0]  valid, we;
    logic        gnt, rvalid;
    logic [63:0] rdata;
    logic [1:0]  e_gnt, e_rsp;
    logic [63:0] e_rdata;
    logic        e_req, e_we;
    int          e_port;
    logic        e_busy, e_spur;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [1:0] valid, logic [1:0] we, logic gnt, logic rvalid,
                              logic [63:0] rdata, logic [1:0] e_gnt, logic [1:0] e_rsp,
                              logic [63:0] e_rdata, logic e_req, logic e_we, int e_port,
                              logic e_busy, logic e_spur, logic [1:0] e_state);
    vec_t v;
    v.valid = valid; v.we = we; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_rsp = e_rsp; v.e_rdata = e_rdata; v.e_req = e_req;
    v.e_we = e_we; v.e_port = e_port; v.e_busy = e_busy; v.e_spur = e_spur;
    v.e_state = e_state;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] we, input logic gnt,
                       input logic rvalid, input logic [63:0] rdata);
    req_valid_i = valid; req_we_i = we; dc_gnt_i = gnt;
    dc_rvalid_i = rvalid; dc_rdata_i = rdata;
  endtask

  task automatic check_vec(input int r, input vec_t v);
    string t;
    t = $sformatf("row%0d", r);
    chk({t, " req_gnt"},   64'(req_gnt_o),      64'(v.e_gnt));
    chk({t, " rsp_valid"}, 64'(rsp_valid_o),    64'(v.e_rsp));
    chk({t, " rsp_rdata"}, rsp_rdata_o,          v.e_rdata);
    chk({t, " dc_req"},    64'(dc_req_o),        64'(v.e_req));
    chk({t, " dc_we"},     64'(dc_we_o),         64'(v.e_we));
    chk({t, " dc_addr"},   dc_addr_o,            (v.e_port < 2) ? p_addr[v.e_port]  : 64'd0);
    chk({t, " dc_wdata"},  dc_wdata_o,           (v.e_port < 2) ? p_wdata[v.e_port] : 64'd0);
    chk({t, " dc_be"},     64'(dc_be_o),         (v.e_port < 2) ? 64'(p_be[v.e_port])   : 64'd0);
    chk({t, " dc_size"},   64'(dc_size_o),       (v.e_port < 2) ? 64'(p_size[v.e_port]) : 64'd0);
    chk({t, " busy"},      64'(busy_o),          64'(v.e_busy));
    chk({t, " spurious"},  64'(spurious_rsp_o),  64'(v.e_spur));
    chk({t, " state"},     64'(dbg_state_o),     64'(v.e_state));
  endtask

  initial begin
    p_addr[0]  = 64'h8000_1000;          p_addr[1]  = 64'h8000_2008;
    p_wdata[0] = 64'h1111_2222_3333_4444; p_wdata[1] = 64'h5555_6666_7777_8888;
    p_be[0]    = 8'hFF;                  p_be[1]    = 8'h0F;
    p_size[0]  = 2'd3;                   p_size[1]  = 2'd2;
    req_addr_i  = {p_addr[1], p_addr[0]};
    req_wdata_i = {p_wdata[1], p_wdata[0]};
    req_be_i    = {p_be[1], p_be[0]};
    req_size_i  = {p_size[1], p_size[0]};

    // valid we gnt rv rdata | gnt rsp rdata req we port busy spur state
    vecs.push_back(mk(2'b01,2'b01,1,0,0,           2'b01,2'b00,0,           1,1,0, 0,0,0)); // single write
    vecs.push_back(mk(2'b00,2'b00,0,0,0,           2'b00,2'b00,0,           0,0,2, 0,0,0));
    vecs.push_back(mk(2'b10,2'b00,1,0,0,           2'b10,2'b00,0,           1,0,1, 0,0,0)); // read t0
    vecs.push_back(mk(2'b00,2'b00,0,0,0,           2'b00,2'b00,0,           0,0,2, 1,0,2));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,           2'b00,2'b00,0,           0,0,2, 1,0,2));
    vecs.push_back(mk(2'b00,2'b00,0,1,64'hDEADBEEF,2'b00,2'b10,64'hDEADBEEF,0,0,2, 1,0,2)); // t0+3
    vecs.push_back(mk(2'b00,2'b00,0,0,0,           2'b00,2'b00,0,           0,0,2, 0,0,0));
    vecs.push_back(mk(2'b11,2'b11,1,0,0,           2'b01,2'b00,0,           1,1,0, 0,0,0)); // alternation
    vecs.push_back(mk(2'b11,2'b11,1,0,0,           2'b10,2'b00,0,           1,1,1, 0,0,0));
    vecs.push_back(mk(2'b11,2'b11,1,0,0,           2'b01,2'b00,0,           1,1,0, 0,0,0));
    vecs.push_back(mk(2'b11,2'b11,1,0,0,           2'b10,2'b00,0,           1,1,1, 0,0,0));
    vecs.push_back(mk(2'b01,2'b01,0,0,0,           2'b00,2'b00,0,           1,1,0, 0,0,0)); // gnt withheld
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(2'b11,2'b11,0,0,0,         2'b00,2'b00,0,           1,1,0, 1,0,1));
    vecs.push_back(mk(2'b11,2'b11,1,0,0,           2'b01,2'b00,0,           1,1,0, 1,0,1));
    vecs.push_back(mk(2'b10,2'b10,1,0,0,           2'b10,2'b00,0,           1,1,1, 0,0,0));
    vecs.push_back(mk(2'b01,2'b00,1,0,0,           2'b01,2'b00,0,           1,0,0, 0,0,0)); // read, then write waits
    vecs.push_back(mk(2'b01,2'b01,0,0,0,           2'b00,2'b00,0,           0,0,2, 1,0,2));
    vecs.push_back(mk(2'b01,2'b01,0,1,64'h12345678,2'b00,2'b01,64'h12345678,0,0,2, 1,0,2));
    vecs.push_back(mk(2'b01,2'b01,1,0,0,           2'b01,2'b00,0,           1,1,0, 0,0,0));
    vecs.push_back(mk(2'b00,2'b00,0,1,64'hAAAA,    2'b00,2'b00,0,           0,0,2, 0,1,0)); // spurious in IDLE
    vecs.push_back(mk(2'b10,2'b00,0,0,0,           2'b00,2'b00,0,           1,0,1, 0,0,0));
    vecs.push_back(mk(2'b10,2'b00,0,1,64'hBBBB,    2'b00,2'b00,0,           1,0,1, 1,1,1)); // spurious in HOLD
    vecs.push_back(mk(2'b10,2'b00,1,0,0,           2'b10,2'b00,0,           1,0,1, 1,0,1));
    vecs.push_back(mk(2'b00,2'b00,0,1,64'h55,      2'b00,2'b10,64'h55,      0,0,2, 1,0,2));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,           2'b00,2'b00,0,           0,0,2, 0,0,0));

    rst_i = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_vec(0, mk(2'b00,2'b00,0,0,0, 2'b00,2'b00,0, 0,0,2, 0,0,0));
    @(posedge clk_i); #1;

    foreach (vecs[r]) begin
      drive(vecs[r].valid, vecs[r].we, vecs[r].gnt, vecs[r].rvalid, vecs[r].rdata);
      @(negedge clk_i);
      check_vec(r + 1, vecs[r]);
      @(posedge clk_i); #1;
    end

    // Reset while a read is outstanding; the late response must not be forwarded.
    drive(2'b01, 2'b00, 1'b1, 1'b0, 64'd0);
    @(negedge clk_i);
    chk("rst_seq read gnt", 64'(req_gnt_o), 64'h1);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_seq busy in wait", 64'(busy_o), 64'h1);
    chk("rst_seq state wait", 64'(dbg_state_o), 64'h2);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_seq state idle", 64'(dbg_state_o), 64'h0);
    chk("rst_seq busy idle", 64'(busy_o), 64'h0);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b1, 64'hCAFE);
    @(negedge clk_i);
    chk("rst_seq late rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_seq late rsp_rdata", rsp_rdata_o, 64'h0);
    chk("rst_seq late spurious", 64'(spurious_rsp_o), 64'h1);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 64'd0);
    @(negedge clk_i);
    chk("rst_seq spurious clears", 64'(spurious_rsp_o), 64'h0);
    @(posedge clk_i); #1;
    drive(2'b11, 2'b11, 1'b1, 1'b0, 64'd0);
    @(negedge clk_i);
    chk("rst_seq rr_ptr reset", 64'(req_gnt_o), 64'h1);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 64'd0);
    repeat (2) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
